// File: rtl/bitslice_mem_responder.sv
// Word-port responder for the bitslice transpose controller: single-port SRAM behind a posted-write FIFO.
// Optional MEMRESP_STALL_EN adds LFSR-driven backpressure on fifo_full_o and WAIT->RESP.
module bitslice_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        read_mem_i,
    input  logic        write_mem_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        read_complete_o,
    output logic        fifo_full_o,
    output logic        fifo_empty_o,
    output logic        axi_error_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] FULL_CNT = FIFO_DEPTH[FW:0];

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] ridx_q, ridx_d;
    logic [FW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW:0]   count_q, count_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rc_q, rc_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] fifo_idx_mem [FIFO_DEPTH];
    logic [31:0]   fifo_data_mem [FIFO_DEPTH];

    logic [31:0]   word_off;
    logic [AW-1:0] addr_idx;
    logic          addr_ok, stall, full, empty, push, pop, wr_err, rd_en;
    logic [AW-1:0] rd_addr;

`ifdef MEMRESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        stall  = (lfsr_q[1:0] == 2'b00);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    // Underflow of the base subtraction wraps high and fails the range test.
    always_comb begin
        word_off = (addr_i - ADDR_BASE) >> 2;
        addr_idx = word_off[AW-1:0];
        addr_ok  = (addr_i[1:0] == 2'b00) && (word_off < DEPTH_WORDS);
        full     = (count_q == FULL_CNT) || stall;
        empty    = (count_q == '0);
        push     = write_mem_i && addr_ok && !full && !(state_q == S_IDLE && read_mem_i);
        pop      = (state_q == S_IDLE) && !empty;
        wr_err   = write_mem_i && !addr_ok;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ridx_d  = ridx_q;
        rd_en   = 1'b0;
        rd_addr = ridx_q;
        unique case (state_q)
            S_IDLE: begin
                if (read_mem_i) begin
                    if (write_mem_i || !addr_ok) begin
                        state_d = S_ERR;
                    end else if (empty) begin
                        ridx_d = addr_idx;
                        if (RD_LATENCY == 1) begin
                            state_d = S_RESP;
                            rd_en   = 1'b1;
                            rd_addr = addr_idx;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = 4'(RD_LATENCY - 2);
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!stall) begin
                    state_d = S_RESP;
                    rd_en   = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rc_d    = (state_d == S_RESP);
        err_d   = wr_err || (state_d == S_ERR);
        rdata_d = rd_en ? mem[rd_addr] : rdata_q;

        wr_ptr_d = push ? wr_ptr_q + FW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (FW+1)'(1);
        else if (!push && pop) count_d = count_q - (FW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ridx_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ridx_q   <= ridx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rc_q     <= rc_d;
            err_q    <= err_d;
        end
    end

    // Storage arrays carry no reset; reset only blocks new pushes and drains.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            fifo_idx_mem[wr_ptr_q]  <= addr_idx;
            fifo_data_mem[wr_ptr_q] <= wdata_i;
        end
        if (!rst_i && pop) begin
            mem[fifo_idx_mem[rd_ptr_q]] <= fifo_data_mem[rd_ptr_q];
        end
    end

    assign rdata_o         = rdata_q;
    assign read_complete_o = rc_q;
    assign fifo_full_o     = full;
    assign fifo_empty_o    = empty;
    assign axi_error_o     = err_q;

endmodule

// File: tb/tb_bitslice_mem_responder.sv
// Directed self-checking bench for bitslice_mem_responder (default build, stall feature off).
module tb_bitslice_mem_responder;

    localparam logic [31:0] B = 32'h1000_0000;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        rc, full, empty, err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bitslice_mem_responder #(
        .ADDR_BASE  (B),
        .DEPTH_WORDS(16),
        .RD_LATENCY (L),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .read_mem_i     (rd),
        .write_mem_i    (wr),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .rdata_o        (rdata),
        .read_complete_o(rc),
        .fifo_full_o    (full),
        .fifo_empty_o   (empty),
        .axi_error_o    (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        tick();
        wr = 1'b0;
        tick();
    endtask

    // Issue a read with an empty FIFO; completion expected on the L-th edge after sampling.
    task automatic rd_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd = 1'b1; addr = a;
        for (int i = 1; i <= L; i++) begin
            tick();
            chk({tag, "_rc"}, 32'(rc), 32'(i == L));
        end
        chk({tag, "_data"}, rdata, exp);
        rd = 1'b0;
        tick();
        chk({tag, "_rc_off"}, 32'(rc), 32'd0);
        chk({tag, "_hold"}, rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        tick();
        tick();
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rc", 32'(rc), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        rst = 1'b0;

        wr_word(B + 32'h30, 32'hC0C0_C0C0);
        wr_word(B + 32'h3C, 32'h0F0F_0F0F);
        wr_word(B, 32'h1234_5678);

        wr = 1'b1; addr = B + 32'h10; wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_pushed", 32'(empty), 32'd0);
        wr = 1'b0;
        tick();
        chk("wr_drained", 32'(empty), 32'd1);
        rd_word("rd_w4", B + 32'h10, 32'hDEAD_BEEF);
        rd_word("rd_w15", B + 32'h3C, 32'h0F0F_0F0F);

        // read behind a posted write waits one drain cycle
        wr = 1'b1; addr = B + 32'h14; wdata = 32'h0000_0077;
        tick();
        wr = 1'b0; rd = 1'b1;
        tick();
        chk("defer_empty", 32'(empty), 32'd1);
        chk("defer_rc0", 32'(rc), 32'd0);
        for (int i = 1; i <= L; i++) begin
            tick();
            chk("defer_rc", 32'(rc), 32'(i == L));
        end
        chk("defer_data", rdata, 32'h0000_0077);
        rd = 1'b0;
        tick();

        rd = 1'b1; addr = B + 32'h2;
        tick();
        chk("misal_err", 32'(err), 32'd1);
        chk("misal_rc", 32'(rc), 32'd0);
        rd = 1'b0;
        tick();
        chk("misal_err_off", 32'(err), 32'd0);

        rd = 1'b1; addr = B + 32'h40;
        tick();
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_rc", 32'(rc), 32'd0);
        rd = 1'b0;
        tick();
        chk("oor_err_off", 32'(err), 32'd0);
        chk("oor_rc_off", 32'(rc), 32'd0);

        wr = 1'b1; addr = B - 32'd4; wdata = 32'h0000_0BAD;
        tick();
        chk("uflow_err", 32'(err), 32'd1);
        chk("uflow_empty", 32'(empty), 32'd1);
        wr = 1'b0;
        tick();
        chk("uflow_err_off", 32'(err), 32'd0);
        chk("uflow_empty2", 32'(empty), 32'd1);
        rd_word("rd_w0", B, 32'h1234_5678);

        rd = 1'b1; wr = 1'b1; addr = B + 32'h18; wdata = 32'h0000_0066;
        tick();
        chk("both_err", 32'(err), 32'd1);
        chk("both_empty", 32'(empty), 32'd1);
        chk("both_rc", 32'(rc), 32'd0);
        rd = 1'b0; wr = 1'b0;
        tick();
        chk("both_err_off", 32'(err), 32'd0);

        // writes during WAIT/RESP cannot drain, so the FIFO fills
        rd = 1'b1; addr = B + 32'h10;
        tick();
        wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = B + 32'h20 + 32'(4 * i);
            wdata = 32'hA0 + 32'(i);
            tick();
            if (i == 2) begin
                chk("fill_rc", 32'(rc), 32'd1);
                chk("fill_rdata", rdata, 32'hDEAD_BEEF);
            end
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);
        rd = 1'b0; addr = B + 32'h30; wdata = 32'hDEAD_0005;
        tick();
        chk("drop_full_off", 32'(full), 32'd0);
        chk("drop_err", 32'(err), 32'd0);
        wr = 1'b0;
        tick();
        tick();
        chk("drain_busy", 32'(empty), 32'd0);
        tick();
        chk("drain_done", 32'(empty), 32'd1);
        rd_word("rd_w8", B + 32'h20, 32'h0000_00A0);
        rd_word("rd_w11", B + 32'h2C, 32'h0000_00A3);
        rd_word("rd_w12", B + 32'h30, 32'hC0C0_C0C0);

        rd = 1'b1; addr = B + 32'h10;
        tick();
        wr = 1'b1; addr = B + 32'h24; wdata = 32'h0000_0099;
        tick();
        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        tick();
        chk("mid_rst_rc", 32'(rc), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abandon_rc", 32'(rc), 32'd0);
        end
        rd_word("rd_w9", B + 32'h24, 32'h0000_00A1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
